seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Upstream feeder for the Moore sequence detector (seq_det_moore).
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on ser_out.
- ser_out connects directly to the detector's serial input `in`.
- Holds one pending word, so back-to-back words stream with no idle gap. The detector therefore sees a continuous bit stream.

Parameters:
- WIDTH, 8, bits per word (legal range WIDTH >= 2).
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first, 0 = shift bit 0 first.
- IDLE_BIT, 0, level driven on ser_out when no word is being shifted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- load_data  input  WIDTH  parallel word to serialize.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit stream to the detector input.
- ser_valid  output  1  ser_out carries a data bit this cycle.
- word_done  output  1  one-cycle pulse coincident with the last bit of each word.
- busy  output  1  shifting in progress, or pending word held.

Behaviour:
- **Reset.** While rst=0 the block is asynchronously forced to:
  - state IDLE, shift register 0, bit counter 0, pending slot empty;
  - ser_out=IDLE_BIT, ser_valid=0, word_done=0, busy=0, load_ready=0.
  - load_ready is forced 0 while rst=0 and is 1 from the first cycle after rst returns to 1.
- **Output timing.** All outputs except load_ready are registered. load_ready = rst & ~pending_full (combinational from registers only, never from load_valid).
- **Accept.** A word is accepted on a rising edge where load_valid & load_ready = 1.
- **States:** IDLE, SHIFT.
- **IDLE:**
  - ser_valid=0, ser_out=IDLE_BIT.
  - On accept, load the shift register from load_data and move to SHIFT.
  - The first bit appears on ser_out with ser_valid=1 in the cycle after the accepting edge (latency 1).
- **SHIFT:**
  - Bit counter runs 0..WIDTH-1. Each edge advances one bit (MSB_FIRST selects the order).
  - ser_valid=1 throughout.
  - On counter WIDTH-1 (last bit): word_done=1 for that one cycle.
- **Accept while in SHIFT:**
  - Normally the word goes to the pending slot; load_ready then drops.
  - Exception: if the current cycle is the last bit and the pending slot is empty, the word loads the shift register directly (bypass).
- **Edge leaving the last bit, in priority order:**
  1. Pending full: pending moves into the shift register, counter=0, stay SHIFT. The pending slot frees, so load_ready=1 in the same cycle the new word's first bit appears.
  2. Else bypass accept on this edge: load the shift register, counter=0, stay SHIFT.
  3. Else go to IDLE: ser_out=IDLE_BIT, ser_valid=0.
- **Simultaneous events:** a pending-to-shift transfer and a new accept cannot coincide, because load_ready=0 while pending is full.
- **busy** = (state==SHIFT) | pending_full.
- **Reset mid-word:** the current and pending words are discarded with no partial word_done. After release, the next accepted word starts from its first bit.
- **load_data** is sampled only on the accepting edge; later changes have no effect.

Test Plan:
- **Single word, MSB first.** Reset low 2 cycles then high; accept 8'hB6 at edge E.
  - ser_out = 1,0,1,1,0,1,1,0 at edges E+1..E+8, ser_valid=1 throughout.
  - word_done=1 only during the bit-8 cycle; ser_valid=0 and ser_out=0 from E+9.
- **LSB first.** MSB_FIRST=0, accept 8'hB6.
  - ser_out = 0,1,1,0,1,1,0,1; same timing as the single-word case.
- **Back-to-back words.** Accept 8'hB6 at E, then 8'h5A at E+2.
  - 16 contiguous valid bits: 10110110 then 01011010.
  - load_ready=0 from E+2 through E+8, 1 at E+9.
  - word_done pulses at E+8 and E+16.
- **Stall on full pending slot.** With 8'hB6 shifting and 8'h5A pending, hold load_valid=1 with 8'hFF.
  - 8'hFF is not accepted until load_ready returns 1 (at E+9); it then follows 8'h5A with no gap.
- **Bypass at the boundary.** Pending empty; present 8'h0F only during the last-bit cycle of 8'hB6.
  - 8'h0F's first bit appears on the very next cycle; ser_valid never drops.
- **Reset mid-word.** Drive rst=0 after 3 bits of 8'hB6 have been shifted.
  - Outputs go to reset values immediately (asynchronously), with no word_done.
  - After release, accepting 8'hA5 yields 1,0,1,0,0,1,0,1 from its first bit.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the Moore sequence detector: accepts words over
// valid/ready and streams them one bit per clock, with a one-word pending slot.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             pend_full, pend_full_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ser_out_nxt, ser_valid_nxt, word_done_nxt, busy_nxt;
  logic             accept, last_bit;

  function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                    input logic [CNT_W-1:0] pos);
    if (MSB_FIRST) return word[LAST - pos];
    else           return word[pos];
  endfunction

  assign load_ready = rst & ~pend_full;
  assign accept     = load_valid & load_ready;
  assign last_bit   = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    cnt_nxt       = cnt;
    pend_nxt      = pend;
    pend_full_nxt = pend_full;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          sreg_nxt  = load_data;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_nxt = cnt + 1'b1;
          if (accept) begin
            pend_nxt      = load_data;
            pend_full_nxt = 1'b1;
          end
        end else if (pend_full) begin
          // Pending word follows immediately; accept is impossible here since ready is low.
          sreg_nxt      = pend;
          cnt_nxt       = '0;
          pend_full_nxt = 1'b0;
        end else if (accept) begin
          sreg_nxt = load_data;
          cnt_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered from the next-state view so the first bit lands one cycle after accept.
    ser_valid_nxt = (state_nxt == SHIFT);
    ser_out_nxt   = ser_valid_nxt ? pick_bit(sreg_nxt, cnt_nxt) : IDLE_BIT;
    word_done_nxt = ser_valid_nxt && (cnt_nxt == LAST);
    busy_nxt      = ser_valid_nxt | pend_full_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      pend_full <= pend_full_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
      word_done <= word_done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share one
// stimulus stream and are checked against a word-queue reference model.
module tb_seq_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;

  logic m_ready, m_out, m_valid, m_done, m_busy;
  logic l_ready, l_out, l_valid, l_done, l_busy;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .ser_out(m_out), .ser_valid(m_valid),
    .word_done(m_done), .busy(m_busy));

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .ser_out(l_out), .ser_valid(l_valid),
    .word_done(l_done), .busy(l_busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: word currently on the wire, bits still to show, pending words.
  logic [W-1:0] cur_word = '0;
  int           rem = 0;
  logic [W-1:0] pend_q[$];

  logic [31:0] msb_sh = '0;
  logic [31:0] lsb_sh = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input bit msb);
    int p;
    p = W - rem;
    if (rem == 0) return 1'b0;
    return msb ? cur_word[W-1-p] : cur_word[p];
  endfunction

  task automatic check_outputs();
    logic rdy;
    rdy = rst && (pend_q.size() == 0);
    chk("m_ready", m_ready, rdy);
    chk("l_ready", l_ready, rdy);
    chk("m_valid", m_valid, rem > 0);
    chk("l_valid", l_valid, rem > 0);
    chk("m_out",   m_out,   exp_bit(1'b1));
    chk("l_out",   l_out,   exp_bit(1'b0));
    chk("m_done",  m_done,  rem == 1);
    chk("l_done",  l_done,  rem == 1);
    chk("m_busy",  m_busy,  (rem > 0) || (pend_q.size() > 0));
    chk("l_busy",  l_busy,  (rem > 0) || (pend_q.size() > 0));
    if (m_valid) msb_sh = {msb_sh[30:0], m_out};
    if (l_valid) lsb_sh = {lsb_sh[30:0], l_out};
  endtask

  task automatic model_edge(input bit acc, input logic [W-1:0] d);
    if (rem > 0) rem--;
    if (rem == 0 && pend_q.size() > 0) begin
      cur_word = pend_q.pop_front();
      rem = W;
    end
    if (acc) begin
      if (rem == 0) begin
        cur_word = d;
        rem = W;
      end else begin
        pend_q.push_back(d);
      end
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, output bit acc);
    load_valid = v;
    load_data  = d;
    @(negedge clk);
    check_outputs();
    acc = v && rst && (pend_q.size() == 0);
    @(posedge clk);
    if (rst) model_edge(acc, d);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, a);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit a;
    cycle(1'b1, d, a);
  endtask

  task automatic do_reset(input int low_cycles);
    rst = 1'b0;
    rem = 0;
    pend_q.delete();
    #1;
    chk("rst_m_out",   m_out,   1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_done",  m_done,  1'b0);
    chk("rst_m_busy",  m_busy,  1'b0);
    chk("rst_m_ready", m_ready, 1'b0);
    chk("rst_l_valid", l_valid, 1'b0);
    chk("rst_l_ready", l_ready, 1'b0);
    idle(low_cycles);
    rst = 1'b1;
  endtask

  initial begin
    bit a;
    int guard;
    idle(2);
    rst = 1'b1;
    idle(1);

    // Single word, both bit orders
    send(8'hB6);
    idle(10);
    chk("single_msb", msb_sh[7:0], 32'hB6);
    chk("single_lsb", lsb_sh[7:0], 32'h6D);

    // Back-to-back plus stall on a full pending slot
    send(8'hB6);
    idle(1);
    send(8'h5A);
    guard = 0;
    a = 1'b0;
    while (!a && guard < 20) begin
      cycle(1'b1, 8'hFF, a);
      guard++;
    end
    chk("stall_accept", a, 1'b1);
    idle(26);
    chk("b2b_msb", msb_sh[23:0], 32'hB65AFF);

    // Bypass at the last-bit boundary
    send(8'hB6);
    idle(7);
    send(8'h0F);
    idle(10);
    chk("bypass_msb", msb_sh[15:0], 32'hB60F);

    // Reset mid-word
    send(8'hB6);
    idle(3);
    do_reset(2);
    send(8'hA5);
    idle(10);
    chk("post_rst_msb", msb_sh[7:0], 32'hA5);
    chk("post_rst_lsb", lsb_sh[7:0], 32'hA5);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        cycle($urandom_range(0, 3) != 0, W'($urandom), a);
      end
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
